// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opsel encodings,
// control-word field positions and the response-register state type.
package alu_arbiter_pkg;

  localparam int CTL_W        = 6;
  localparam int CTL_OPSEL_HI = 5;
  localparam int CTL_OPSEL_LO = 3;
  localparam int CTL_SUB      = 2;
  localparam int CTL_UNSIGNED = 1;
  localparam int CTL_ARITH    = 0;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SLL  = 3'b001,
    OP_SLT  = 3'b010,
    OP_SLTU = 3'b011,
    OP_XOR  = 3'b100,
    OP_SR   = 3'b101,
    OP_OR   = 3'b110,
    OP_AND  = 3'b111
  } opsel_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, one consumer and the arbiter.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic              i_req0_valid;
  logic [CTL_W-1:0]  i_req0_ctl;
  logic [31:0]       i_req0_op1;
  logic [31:0]       i_req0_op2;
  logic              o_req0_ready;
  logic              i_req1_valid;
  logic [CTL_W-1:0]  i_req1_ctl;
  logic [31:0]       i_req1_op1;
  logic [31:0]       i_req1_op2;
  logic              o_req1_ready;
  logic              o_rsp_valid;
  logic              o_rsp_id;
  logic [31:0]       o_rsp_result;
  logic              o_rsp_eq;
  logic              o_rsp_slt;
  logic              i_rsp_ready;

  modport master (
    output i_req0_valid, i_req0_ctl, i_req0_op1, i_req0_op2,
    output i_req1_valid, i_req1_ctl, i_req1_op1, i_req1_op2,
    output i_rsp_ready,
    input  o_req0_ready, o_req1_ready,
    input  o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_eq, o_rsp_slt
  );

  modport slave (
    input  i_req0_valid, i_req0_ctl, i_req0_op1, i_req0_op2,
    input  i_req1_valid, i_req1_ctl, i_req1_op1, i_req1_op2,
    input  i_rsp_ready,
    output o_req0_ready, o_req1_ready,
    output o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_eq, o_rsp_slt
  );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU. SLT and SLTU opsels give the same result: the
// signedness of the compare comes from the control word's unsigned bit.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [CTL_W-1:0] i_ctl,
  input  logic [31:0]      i_op1,
  input  logic [31:0]      i_op2,
  output logic [31:0]      o_result,
  output logic             o_eq,
  output logic             o_slt
);

  opsel_e      opsel;
  logic        sub_en;
  logic        uns;
  logic        arith;
  logic [4:0]  shamt;
  logic [31:0] sum;

  // Decode the control word, form compare flags and select the result.
  always_comb begin
    opsel  = opsel_e'(i_ctl[CTL_OPSEL_HI:CTL_OPSEL_LO]);
    sub_en = i_ctl[CTL_SUB];
    uns    = i_ctl[CTL_UNSIGNED];
    arith  = i_ctl[CTL_ARITH];
    shamt  = i_op2[4:0];
    sum    = sub_en ? (i_op1 - i_op2) : (i_op1 + i_op2);
    o_eq   = (i_op1 == i_op2);
    o_slt  = uns ? (i_op1 < i_op2) : ($signed(i_op1) < $signed(i_op2));
    case (opsel)
      OP_ADD:          o_result = sum;
      OP_SLL:          o_result = i_op1 << shamt;
      OP_SLT, OP_SLTU: o_result = {31'd0, o_slt};
      OP_XOR:          o_result = i_op1 ^ i_op2;
      OP_SR:           o_result = arith ? 32'($signed(i_op1) >>> shamt) : (i_op1 >> shamt);
      OP_OR:           o_result = i_op1 | i_op2;
      OP_AND:          o_result = i_op1 & i_op2;
      default:         o_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a single
// response register that can be reloaded in the same cycle it is consumed.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  alu_arbiter_if.slave bus
);

  rsp_state_e       state_q, state_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic [31:0]      result_q, result_d;
  logic             eq_q, eq_d;
  logic             slt_q, slt_d;

  logic             slot_free;
  logic             gnt_id;
  logic             rdy0;
  logic             rdy1;
  logic             accept;
  logic [CTL_W-1:0] alu_ctl;
  logic [31:0]      alu_op1;
  logic [31:0]      alu_op2;
  logic [31:0]      alu_result;
  logic             alu_eq;
  logic             alu_slt;

  // Pick the granted requester and steer its fields into the ALU; readies
  // depend only on valids, prio and response-slot state, never on operands.
  always_comb begin
    slot_free = (state_q == ST_EMPTY) || bus.i_rsp_ready;
    gnt_id    = 1'b0;
    if (bus.i_req0_valid && bus.i_req1_valid) begin
      gnt_id = prio_q;
    end else if (bus.i_req1_valid) begin
      gnt_id = 1'b1;
    end else begin
      gnt_id = 1'b0;
    end
    rdy0    = i_rst_n && slot_free && bus.i_req0_valid && !gnt_id;
    rdy1    = i_rst_n && slot_free && bus.i_req1_valid &&  gnt_id;
    accept  = rdy0 || rdy1;
    alu_ctl = gnt_id ? bus.i_req1_ctl : bus.i_req0_ctl;
    alu_op1 = gnt_id ? bus.i_req1_op1 : bus.i_req0_op1;
    alu_op2 = gnt_id ? bus.i_req1_op2 : bus.i_req0_op2;
  end

  alu u_alu (
    .i_ctl    (alu_ctl),
    .i_op1    (alu_op1),
    .i_op2    (alu_op2),
    .o_result (alu_result),
    .o_eq     (alu_eq),
    .o_slt    (alu_slt)
  );

  // Response-slot next state, response load on accept, round-robin update.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    id_d     = id_q;
    result_d = result_q;
    eq_d     = eq_q;
    slt_d    = slt_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = ST_FULL;
        else        state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (bus.i_rsp_ready && !accept) state_d = ST_EMPTY;
        else                            state_d = ST_FULL;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (accept) begin
      prio_d   = ~gnt_id;
      id_d     = gnt_id;
      result_d = alu_result;
      eq_d     = alu_eq;
      slt_d    = alu_slt;
    end else begin
      prio_d   = prio_q;
    end
  end

  // State and response registers; reset discards any held response at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_EMPTY;
      prio_q   <= 1'b0;
      id_q     <= 1'b0;
      result_q <= 32'd0;
      eq_q     <= 1'b0;
      slt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      id_q     <= id_d;
      result_q <= result_d;
      eq_q     <= eq_d;
      slt_q    <= slt_d;
    end
  end

  assign bus.o_req0_ready = rdy0;
  assign bus.o_req1_ready = rdy1;
  assign bus.o_rsp_valid  = (state_q == ST_FULL);
  assign bus.o_rsp_id     = id_q;
  assign bus.o_rsp_result = result_q;
  assign bus.o_rsp_eq     = eq_q;
  assign bus.o_rsp_slt    = slt_q;

endmodule
